ps2_key_decoder: RTL and testbench

Producer end of the 48-bit `keys` held-key vector that the piano player/record logic consumes. The block receives PS/2 keyboard frames (scan-code set 2) and checks each frame. It tracks make, break and extended sequences and keeps one held/released bit per piano key. The block sits between the PS/2 pins and the player control block, which reads `keys` directly.

---
 rtl/ps2_key_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// -----------------------------------------------------------------------------
// ps2_key_decoder
//
// Receives PS/2 keyboard frames (scan-code set 2), checks each frame and keeps
// a held/released bit per piano key for the player/record logic.
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-low reset
//   ps2_clk    in   1  raw PS/2 clock from the keyboard
//   ps2_data   in   1  raw PS/2 data from the keyboard
//   keys       out 48  key-held vector, bit i set while mapped key i is down
//   rx_byte    out  8  last accepted scan-code byte
//   rx_valid   out  1  one-cycle pulse when rx_byte is updated
//   frame_err  out  1  one-cycle pulse on parity/start/stop error or timeout
// -----------------------------------------------------------------------------
module ps2_key_decoder #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [47:0] keys,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   output logic        frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   // Set-2 scan code for each key index.
   localparam logic [7:0] KEY_MAP [48] = '{
      8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
      8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C,
      8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h4E, 8'h54, 8'h55, 8'h5B, 8'h1C, 8'h2B, 8'h42,
      8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07
   };

   typedef enum logic {R_IDLE, R_SHIFT} rx_state_t;
   typedef enum logic [1:0] {D_IDLE, D_BREAK, D_EXT, D_EXT_BREAK} dec_state_t;

   // ---------------------------------------------------------------- input conditioning
   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic [FW-1:0] filt_cnt;
   logic          filt_clk, filt_clk_d;
   logic          strobe;

   // Synchronizers and filter reset to the idle (high) bus level so that
   // release of reset never looks like a falling edge.
   // NOTE: every clocked block uses non-blocking (<=) assignments so all
   // registers update together from pre-edge values; blocking here would
   // collapse the two synchronizer stages into one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         dat_s1     <= 1'b1;
         dat_s2     <= 1'b1;
         filt_cnt   <= '0;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
      end else begin
         clk_s1     <= ps2_clk;
         clk_s2     <= clk_s1;
         dat_s1     <= ps2_data;
         dat_s2     <= dat_s1;
         filt_clk_d <= filt_clk;
         // Count consecutive cycles the synchronized level disagrees with the
         // filtered one; any agreement restarts the count, so short glitches die.
         if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign strobe = filt_clk_d & ~filt_clk;

   // ---------------------------------------------------------------- receive FSM
   rx_state_t     rx_state, rx_next;
   logic [3:0]    bit_cnt;
   logic [9:0]    shift_q;     // start, data[7:0], parity once 10 bits are in
   logic [WW-1:0] wd_cnt;      // cycles since the last strobe while in R_SHIFT
   logic          shift_en, frame_done, wd_timeout, frame_ok;

   // Stop bit is checked live as it arrives on the 11th strobe.
   assign frame_ok = ~shift_q[0] & (^shift_q[9:1]) & dat_s2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rx_state <= R_IDLE;
      else        rx_state <= rx_next;
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement can leave a signal unassigned and infer
   // a latch.
   always_comb begin
      rx_next    = rx_state;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      wd_timeout = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (strobe) begin
               shift_en = 1'b1;
               rx_next  = R_SHIFT;
            end
         end
         R_SHIFT: begin
            if (strobe) begin
               if (bit_cnt == 4'd10) begin
                  frame_done = 1'b1;
                  rx_next    = R_IDLE;
               end else begin
                  shift_en = 1'b1;
               end
            end else if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
               // Abort on the edge where the count would reach TIMEOUT_CYC,
               // so frame_err lands exactly TIMEOUT_CYC cycles after the strobe.
               wd_timeout = 1'b1;
               rx_next    = R_IDLE;
            end
         end
         default: rx_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt   <= '0;
         shift_q   <= '0;
         wd_cnt    <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (shift_en) shift_q <= {dat_s2, shift_q[9:1]};

         if (rx_next == R_IDLE) bit_cnt <= '0;
         else if (shift_en)     bit_cnt <= bit_cnt + 1'b1;

         if (rx_next == R_IDLE) wd_cnt <= '0;
         else if (strobe)       wd_cnt <= WW'(1);
         else                   wd_cnt <= wd_cnt + 1'b1;

         rx_valid  <= frame_done & frame_ok;
         frame_err <= (frame_done & ~frame_ok) | wd_timeout;
         if (frame_done && frame_ok) rx_byte <= shift_q[8:1];
      end
   end

   // ---------------------------------------------------------------- decode FSM
   dec_state_t  dec_state, dec_next;
   logic [47:0] key_match, keys_next;

   // One-hot match of the byte against the key map; codes are distinct, so at
   // most one bit is set.
   always_comb begin
      key_match = '0;
      for (int i = 0; i < 48; i++) key_match[i] = (rx_byte == KEY_MAP[i]);
   end

   always_comb begin
      dec_next  = dec_state;
      keys_next = keys;
      if (rx_valid) begin
         case (dec_state)
            D_IDLE: begin
               if (rx_byte == 8'hF0)                          dec_next  = D_BREAK;
               else if (rx_byte == 8'hE0)                     dec_next  = D_EXT;
               else if (rx_byte == 8'h00 || rx_byte == 8'hFF) keys_next = '0;
               else                                           keys_next = keys | key_match;
            end
            D_BREAK: begin
               keys_next = keys & ~key_match;
               dec_next  = D_IDLE;
            end
            D_EXT: begin
               // Extended keys are never mapped; only a break prefix matters.
               dec_next = (rx_byte == 8'hF0) ? D_EXT_BREAK : D_IDLE;
            end
            default: dec_next = D_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_state <= D_IDLE;
         keys      <= '0;
      end else begin
         dec_state <= dec_next;
         keys      <= keys_next;
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

   localparam int FILT = 8;
   localparam int TMO  = 1000;
   localparam int H    = 16;      // PS/2 half bit period in clk cycles

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [47:0] keys;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        frame_err;

   ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keys      (keys),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   int unsigned last_fall = 0;
   always @(posedge clk) cyc++;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------ reference model
   logic [7:0] key_map [48] = '{
      8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
      8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C,
      8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h4E, 8'h54, 8'h55, 8'h5B, 8'h1C, 8'h2B, 8'h42,
      8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07
   };

   logic [47:0] m_keys = '0;
   logic [7:0]  m_last = '0;
   logic [7:0]  m_pre[$];          // prefix bytes of the key event in progress

   function automatic int map_idx(input logic [7:0] b);
      for (int i = 0; i < 48; i++) if (key_map[i] == b) return i;
      return -1;
   endfunction

   // A key event is an optional prefix (F0, E0 or E0 F0) followed by one code.
   task automatic model_byte(input logic [7:0] b);
      int idx;
      idx = map_idx(b);
      if (b == 8'hF0 && (m_pre.size() == 0 || (m_pre.size() == 1 && m_pre[0] == 8'hE0)))
         m_pre.push_back(b);
      else if (b == 8'hE0 && m_pre.size() == 0)
         m_pre.push_back(b);
      else begin
         if (m_pre.size() == 0) begin
            if (b == 8'h00 || b == 8'hFF) m_keys = '0;
            else if (idx >= 0)            m_keys[idx] = 1'b1;
         end else if (m_pre.size() == 1 && m_pre[0] == 8'hF0) begin
            if (idx >= 0) m_keys[idx] = 1'b0;
         end
         m_pre.delete();
      end
   endtask

   // ------------------------------------------------------------ scoreboard
   typedef struct {
      bit          is_err;
      bit          timeout;
      logic [7:0]  data;
      logic [7:0]  last;
      logic [47:0] keys_before;
      logic [47:0] keys_after;
   } exp_t;

   exp_t sb[$];

   initial begin
      exp_t e;
      int unsigned dt;
      forever begin
         @(negedge clk);
         if (reset && (rx_valid || frame_err)) begin
            if (sb.size() == 0) begin
               check("unexpected_event", {rx_valid, frame_err}, 2'b00);
            end else begin
               e  = sb.pop_front();
               dt = cyc - last_fall;
               check("frame_err_pulse", frame_err, e.is_err);
               check("rx_valid_pulse", rx_valid, !e.is_err);
               check("rx_byte", rx_byte, e.is_err ? e.last : e.data);
               check("latency", dt, e.timeout ? (FILT + 2 + TMO) : (FILT + 3));
               check("keys_at_n1", keys, e.keys_before);
               @(negedge clk);
               check("keys_at_n2", keys, e.keys_after);
               check("pulse_width", {rx_valid, frame_err}, 2'b00);
            end
         end
      end
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL global_timeout: cycle %0d reached without finishing", cyc);
      $fatal(1, "simulation bound exceeded");
   end

   // ------------------------------------------------------------ stimulus
   task automatic drive_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (H / 2) @(negedge clk);
         ps2_clk   = 1'b0;
         last_fall = cyc;
         repeat (H) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (H / 2) @(negedge clk);
      end
      ps2_data = 1'b1;
      repeat (2 * H) @(negedge clk);
   endtask

   // err_kind: 0 good, 1 parity, 2 start, 3 stop
   function automatic logic [10:0] make_frame(input logic [7:0] b, input int err_kind);
      logic par;
      par = ~(^b);
      if (err_kind == 1) par = ~par;
      return {(err_kind != 3), par, b, (err_kind == 2)};
   endfunction

   task automatic send(input logic [7:0] b, input int err_kind);
      exp_t e;
      e.keys_before = m_keys;
      e.timeout     = 1'b0;
      if (err_kind == 0) begin
         model_byte(b);
         m_last   = b;
         e.is_err = 1'b0;
      end else begin
         e.is_err = 1'b1;
      end
      e.data       = b;
      e.last       = m_last;
      e.keys_after = m_keys;
      sb.push_back(e);
      drive_bits(make_frame(b, err_kind), 11);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", sb.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      exp_t e;
      int r;
      logic [7:0] b;

      repeat (5) @(negedge clk);
      check("reset_keys", keys, '0);
      check("reset_rx_byte", rx_byte, '0);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      reset = 1'b1;
      repeat (20) @(negedge clk);

      // Basic make/break
      send(8'h1A, 0);
      send(8'hF0, 0); send(8'h1A, 0);
      // Multiple keys and overrun
      send(8'h1A, 0); send(8'h15, 0); send(8'h07, 0);
      send(8'hF0, 0); send(8'h15, 0);
      send(8'hFF, 0);
      // Bad parity, then a good frame
      send(8'h1A, 1);
      send(8'h1B, 0);
      // Extended prefix
      send(8'hE0, 0); send(8'h1A, 0);
      send(8'h1A, 0);
      send(8'hE0, 0); send(8'hF0, 0); send(8'h1A, 0);
      send(8'h1B, 0);
      wait_drain();

      // Timeout after 5 bits
      e.is_err = 1'b1; e.timeout = 1'b1; e.data = 8'h00; e.last = m_last;
      e.keys_before = m_keys; e.keys_after = m_keys;
      sb.push_back(e);
      drive_bits(make_frame(8'h15, 0), 5);
      repeat (TMO + 100) @(negedge clk);
      send(8'h15, 0);
      wait_drain();

      // Randomized traffic
      for (int k = 0; k < 50; k++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      b = key_map[$urandom_range(0, 47)];
         else if (r < 75) b = 8'hF0;
         else if (r < 85) b = 8'hE0;
         else if (r < 90) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         else             b = 8'($urandom_range(0, 255));
         send(b, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
      end
      wait_drain();

      // Reset in mid-frame
      send(8'h1A, 0); send(8'h1A, 0);
      wait_drain();
      drive_bits(make_frame(8'h1B, 0), 6);
      reset = 1'b0;
      #1;
      check("midreset_keys", keys, '0);
      check("midreset_rx_byte", rx_byte, '0);
      check("midreset_rx_valid", rx_valid, 1'b0);
      check("midreset_frame_err", frame_err, 1'b0);
      m_keys = '0; m_last = '0; m_pre.delete();
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      send(8'h05, 0);

      // Short glitch on ps2_clk must not produce a strobe
      ps2_clk = 1'b0;
      repeat (FILT - 3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (50) @(negedge clk);
      send(8'h1A, 0);
      wait_drain();
      check("final_keys", keys, m_keys);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
